gray_checker: RTL and testbench
===============================

# gray_checker

Downstream monitor for the 3-bit Gray counter stage. Samples the Gray code and overflow flag every clock, converts the code to binary, and checks that each new sample is either unchanged or exactly one step forward. Counts legal steps and illegal jumps, pulses on each 7→0 wrap, and flags overflow behaviour that does not match the observed sequence. Used on the board and in benches as a self-checking sink for the counter.

## Interface
Parameters:
- CNT_WIDTH, 8, width of the Steps and Errors counters; both saturate at 2^CNT_WIDTH−1

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; clears all state and outputs
- Resync  input  1  synchronous, active-high; same effect as Reset at the next edge; highest priority after Reset
- GrayIn  input  3  Gray code from the upstream counter
- OverflowIn  input  1  overflow flag from the upstream counter
- Binary  output  3  registered binary value of the last sample
- Steps  output  CNT_WIDTH  number of legal +1 steps counted in TRACK
- Errors  output  CNT_WIDTH  number of illegal transitions seen
- Wrap  output  1  one-cycle pulse when a counted step goes 7→0
- Error  output  1  sticky; set on the first illegal transition
- OvfErr  output  1  sticky; set when OverflowIn misbehaves
- State  output  2  current FSM state: 0 INIT, 1 TRACK, 2 FAULT

## Operation
- Conversion: b2=g2, b1=g2^g1, b0=b1^g0. The previous binary sample is held in register prev.
- delta = (bin_now − prev) mod 8, computed in 3 bits. A delta of 0 or 1 is legal. Any other delta, including 7 (a backward step), is illegal.
- FSM:
  - INIT: captures the sample into prev and Binary and performs no checks. Always moves to TRACK on the next edge.
  - TRACK:
    - delta 0: hold; no counter change.
    - delta 1: Steps += 1 (saturating). If prev=7, Wrap is 1 for this cycle.
    - Illegal delta: Errors += 1 (saturating), Error is set, and the FSM moves to FAULT. Steps does not change.
  - FAULT:
    - Steps is frozen and Wrap is never pulsed.
    - Every illegal delta increments Errors and resets the good-run counter to 0.
    - Each legal delta increments the good-run counter (2 bits). After the second consecutive legal sample, the FSM returns to TRACK; that sample is not counted in Steps.
- prev updates on every sample in every state.
- Overflow check, in TRACK and FAULT only:
  - OverflowIn rising (0→1 relative to its previous sample) is legal only on a sample whose transition is prev=7 → bin_now=0. Any other rise sets OvfErr.
  - OverflowIn falling (1→0) sets OvfErr.
  - The previous OverflowIn value is registered, including in INIT.
- Error and OvfErr are cleared only by Reset or Resync.
- Simultaneous events: an illegal delta and an overflow fault on the same sample update both Errors and OvfErr. When Resync=1, all other inputs are ignored on that edge.

## Timing
- All outputs are registered. The sample present before edge k appears on the outputs after edge k, a latency of 1 cycle.
- Wrap is high for exactly one cycle per counted wrap.
- Reset values: Binary=0, Steps=0, Errors=0, Wrap=0, Error=0, OvfErr=0, State=INIT. prev, the previous OverflowIn register and the good-run counter are also 0.
- Reset asserted mid-sequence: outputs go to reset values immediately, without waiting for a clock edge. After Reset is released, the first edge is an INIT capture with no check.
- Saturation: at the counter maximum, further increments leave the value unchanged and no wrap occurs.

## Test plan
- Reset, then drive Gray 000,001,011,010,110,111,101,100,000, one per cycle → Steps=8, Wrap pulses once on the 100→000 sample, Error=0, final State=TRACK.
- Same sequence with OverflowIn rising on the 100→000 sample → OvfErr=0. Then OverflowIn rising on a 001→011 sample instead → OvfErr=1.
- In TRACK, jump from Gray 001 (binary 1) to 110 (binary 4) → Errors=1, Error=1, State=FAULT. Then drive 111, 101 → State=TRACK after the second sample, and Steps is unchanged.
- Backward step 011→001 → Errors increments and State=FAULT. Then 000 (another backward step) → Errors=2 and the FSM stays in FAULT.
- Hold GrayIn=010 for 10 cycles → Steps, Errors and Wrap are unchanged, and Binary=3.
- CNT_WIDTH=2, drive 5 legal steps → Steps=3 (saturated). Pulse Resync → all outputs are 0 and State=INIT. Assert Reset between edges → outputs clear before the next edge.

Source files
------------

// File: rtl/gray_checker.sv
// Self-checking sink for the 3-bit Gray counter: converts each sample to binary,
// tracks legal +1 steps, counts illegal jumps and polices the overflow flag.
module gray_checker #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Resync,
    input  logic [2:0]           GrayIn,
    input  logic                 OverflowIn,
    output logic [2:0]           Binary,
    output logic [CNT_WIDTH-1:0] Steps,
    output logic [CNT_WIDTH-1:0] Errors,
    output logic                 Wrap,
    output logic                 Error,
    output logic                 OvfErr,
    output logic [1:0]           State
);
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [2:0]           prev_q, prev_d;
    logic                 ovf_q, ovf_d;
    logic [1:0]           good_q, good_d;
    logic [CNT_WIDTH-1:0] steps_q, steps_d;
    logic [CNT_WIDTH-1:0] errors_q, errors_d;
    logic                 wrap_q, wrap_d;
    logic                 error_q, error_d;
    logic                 ovferr_q, ovferr_d;

    logic [2:0] bin_now;
    logic [2:0] delta;
    logic       legal;
    logic       step_fwd;
    logic       ovf_rise;
    logic       ovf_fall;
    logic       ovf_bad;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign bin_now  = gray2bin(GrayIn);
    assign delta    = bin_now - prev_q;
    assign legal    = (delta == 3'd0) || (delta == 3'd1);
    assign step_fwd = (delta == 3'd1);
    assign ovf_rise = OverflowIn & ~ovf_q;
    assign ovf_fall = ~OverflowIn & ovf_q;
    // A rise is only legitimate on the 7 -> 0 transition of the counter
    assign ovf_bad  = ovf_fall | (ovf_rise & ~((prev_q == 3'd7) && (bin_now == 3'd0)));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_INIT;
        end else if (Resync) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_TRACK;
            S_TRACK: if (!legal) state_d = S_FAULT;
            S_FAULT: if (legal && (good_q == 2'd1)) state_d = S_TRACK;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        prev_d   = bin_now;
        ovf_d    = OverflowIn;
        good_d   = good_q;
        steps_d  = steps_q;
        errors_d = errors_q;
        wrap_d   = 1'b0;
        error_d  = error_q;
        ovferr_d = ovferr_q;
        case (state_q)
            S_TRACK: begin
                good_d = 2'd0;
                if (step_fwd) begin
                    steps_d = sat_inc(steps_q);
                    wrap_d  = (prev_q == 3'd7);
                end else if (!legal) begin
                    errors_d = sat_inc(errors_q);
                    error_d  = 1'b1;
                end
                if (ovf_bad) ovferr_d = 1'b1;
            end
            S_FAULT: begin
                // Second consecutive legal sample re-arms tracking; counter restarts
                if (legal) begin
                    good_d = (good_q == 2'd1) ? 2'd0 : good_q + 2'd1;
                end else begin
                    good_d   = 2'd0;
                    errors_d = sat_inc(errors_q);
                    error_d  = 1'b1;
                end
                if (ovf_bad) ovferr_d = 1'b1;
            end
            default: good_d = 2'd0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_q   <= 3'd0;
            ovf_q    <= 1'b0;
            good_q   <= 2'd0;
            steps_q  <= '0;
            errors_q <= '0;
            wrap_q   <= 1'b0;
            error_q  <= 1'b0;
            ovferr_q <= 1'b0;
        end else if (Resync) begin
            prev_q   <= 3'd0;
            ovf_q    <= 1'b0;
            good_q   <= 2'd0;
            steps_q  <= '0;
            errors_q <= '0;
            wrap_q   <= 1'b0;
            error_q  <= 1'b0;
            ovferr_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            ovf_q    <= ovf_d;
            good_q   <= good_d;
            steps_q  <= steps_d;
            errors_q <= errors_d;
            wrap_q   <= wrap_d;
            error_q  <= error_d;
            ovferr_q <= ovferr_d;
        end
    end

    assign Binary = prev_q;
    assign Steps  = steps_q;
    assign Errors = errors_q;
    assign Wrap   = wrap_q;
    assign Error  = error_q;
    assign OvfErr = ovferr_q;
    assign State  = state_q;
endmodule

// File: tb/tb_gray_checker.sv
// Bench for gray_checker: a reference model pushes expected outputs per sample,
// and each scenario task pops and compares them after the sampling edge.
module tb_gray_checker;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Resync = 1'b0;
    logic [2:0] GrayIn = 3'd0;
    logic       OverflowIn = 1'b0;

    logic [2:0] Binary,  Binary2;
    logic [7:0] Steps,   Errors;
    logic [1:0] Steps2,  Errors2;
    logic       Wrap, Error, OvfErr, Wrap2, Error2, OvfErr2;
    logic [1:0] State,   State2;

    gray_checker #(.CNT_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Resync(Resync), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
        .Binary(Binary), .Steps(Steps), .Errors(Errors), .Wrap(Wrap), .Error(Error),
        .OvfErr(OvfErr), .State(State)
    );

    gray_checker #(.CNT_WIDTH(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Resync(Resync), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
        .Binary(Binary2), .Steps(Steps2), .Errors(Errors2), .Wrap(Wrap2), .Error(Error2),
        .OvfErr(OvfErr2), .State(State2)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [23:0] v;
        logic [3:0]  v2;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // reference model state
    logic [1:0] m_state;
    logic [2:0] m_prev;
    logic       m_ovf, m_wrap, m_err, m_ovferr;
    int         m_good;
    logic [7:0] m_steps, m_errors;
    logic [1:0] m_steps2, m_errors2;

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        for (int i = 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [2:0] b2g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [27:0] obs();
        return {State, OvfErr, Error, Wrap, Errors, Steps, Binary, Steps2, Errors2};
    endfunction

    task automatic model_reset();
        m_state = 2'd0; m_prev = 3'd0; m_ovf = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        m_ovferr = 1'b0; m_good = 0; m_steps = 8'd0; m_errors = 8'd0;
        m_steps2 = 2'd0; m_errors2 = 2'd0;
    endtask

    task automatic model_sample(input logic [2:0] g, input logic o);
        logic [2:0] b, d;
        logic ok;
        b = g2b(g);
        d = b - m_prev;
        ok = (d == 3'd0) || (d == 3'd1);
        m_wrap = 1'b0;
        if (m_state == 2'd0) begin
            m_state = 2'd1;
        end else begin
            if ((o && !m_ovf && !(m_prev == 3'd7 && b == 3'd0)) || (!o && m_ovf)) m_ovferr = 1'b1;
            if (m_state == 2'd1) begin
                if (d == 3'd1) begin
                    if (m_steps != 8'hFF) m_steps++;
                    if (m_steps2 != 2'd3) m_steps2++;
                    if (m_prev == 3'd7) m_wrap = 1'b1;
                end else if (!ok) begin
                    if (m_errors != 8'hFF) m_errors++;
                    if (m_errors2 != 2'd3) m_errors2++;
                    m_err = 1'b1;
                    m_state = 2'd2;
                    m_good = 0;
                end
            end else begin
                if (ok) begin
                    m_good++;
                    if (m_good == 2) begin
                        m_state = 2'd1;
                        m_good = 0;
                    end
                end else begin
                    if (m_errors != 8'hFF) m_errors++;
                    if (m_errors2 != 2'd3) m_errors2++;
                    m_good = 0;
                end
            end
        end
        m_prev = b;
        m_ovf = o;
    endtask

    task automatic step(input logic [2:0] g, input logic o, input logic rs);
        exp_t e;
        GrayIn = g;
        OverflowIn = o;
        Resync = rs;
        if (rs) model_reset();
        else model_sample(g, o);
        e.v  = {m_state, m_ovferr, m_err, m_wrap, m_errors, m_steps, m_prev};
        e.v2 = {m_steps2, m_errors2};
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Resync = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_tests++;
        if (obs() !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_state got %h want 0", obs());
        end
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_count();
        logic [2:0] tbl [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        exp_t e;
        int wraps = 0;
        for (int i = 0; i < 9; i++) begin
            step(tbl[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL count[%0d] got %h want %h", i, obs(), e);
            end
            if (Wrap) wraps++;
        end
        n_tests++;
        if (Steps !== 8'd8 || wraps != 1 || Error !== 1'b0 || State !== 2'd1) begin
            n_fail++;
            $display("FAIL count_final steps=%0d wraps=%0d err=%b state=%0d want 8 1 0 1", Steps, wraps, Error, State);
        end
        n_tests++;
        if (Steps2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_steps2 got %0d want 3", Steps2);
        end
    endtask

    task automatic test_ovf();
        logic [2:0] tbl [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        exp_t e;
        step(3'd0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL ovf_resync got %h want %h", obs(), e);
        end
        for (int i = 0; i < 9; i++) begin
            step(tbl[i], (i == 8), 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL ovf_good[%0d] got %h want %h", i, obs(), e);
            end
        end
        n_tests++;
        if (OvfErr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_wrap got %b want 0", OvfErr);
        end
        step(3'd0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(tbl[i], (i == 2), 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL ovf_bad[%0d] got %h want %h", i, obs(), e);
            end
        end
        n_tests++;
        if (OvfErr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_early_rise got %b want 1", OvfErr);
        end
    endtask

    task automatic test_jump();
        logic [2:0] tbl [5] = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b101};
        exp_t e;
        step(3'd0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            step(tbl[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL jump[%0d] got %h want %h", i, obs(), e);
            end
            if (i == 2) begin
                n_tests++;
                if (Errors !== 8'd1 || Error !== 1'b1 || State !== 2'd2) begin
                    n_fail++;
                    $display("FAIL jump_fault errors=%0d err=%b state=%0d want 1 1 2", Errors, Error, State);
                end
            end
        end
        n_tests++;
        if (State !== 2'd1 || Steps !== 8'd1) begin
            n_fail++;
            $display("FAIL jump_recover state=%0d steps=%0d want 1 1", State, Steps);
        end
    endtask

    task automatic test_backward();
        logic [2:0] tbl [5] = '{3'b000, 3'b001, 3'b011, 3'b001, 3'b000};
        exp_t e;
        step(3'd0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            step(tbl[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL backward[%0d] got %h want %h", i, obs(), e);
            end
        end
        n_tests++;
        if (Errors !== 8'd2 || State !== 2'd2) begin
            n_fail++;
            $display("FAIL backward_final errors=%0d state=%0d want 2 2", Errors, State);
        end
    endtask

    task automatic test_hold();
        logic [2:0] tbl [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        exp_t e;
        step(3'd0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(tbl[i], 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 10; i++) begin
            step(3'b010, 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e || Binary !== 3'd3 || Steps !== 8'd3 || Errors !== 8'd0 || Wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d] got %h want %h (bin=3 steps=3)", i, obs(), e);
            end
        end
    endtask

    task automatic test_saturation_resync();
        logic [2:0] tbl [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
        exp_t e;
        step(3'd0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            step(tbl[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL sat[%0d] got %h want %h", i, obs(), e);
            end
        end
        n_tests++;
        if (Steps2 !== 2'd3 || Steps !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_final steps2=%0d steps=%0d want 3 5", Steps2, Steps);
        end
        step(3'b101, 1'b1, 1'b1);
        void'(sb.pop_front());
        n_tests++;
        if (obs() !== 28'd0) begin
            n_fail++;
            $display("FAIL resync_clear got %h want 0", obs());
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [2:0] tbl [3] = '{3'b000, 3'b001, 3'b011};
        for (int i = 0; i < 3; i++) begin
            step(tbl[i], 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== 28'd0) begin
            n_fail++;
            $display("FAIL async_reset got %h want 0", obs());
        end
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        step(3'b010, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || State !== 2'd1 || Binary !== 3'd3 || Steps !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_init got %h want %h", obs(), e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] g;
        logic o;
        o = OverflowIn;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 7) g = b2g(m_prev + 3'($urandom_range(0, 1)));
            else g = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) o = ~o;
            step(g, o, ($urandom_range(0, 39) == 0));
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL random[%0d] got %h want %h", i, obs(), e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_ovf();
        test_jump();
        test_backward();
        test_hold();
        test_saturation_resync();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
